// File: rtl/adbg_crc_pkg.sv
// Shared constants and FSM state type for the adbg CRC engine and its helpers.
package adbg_crc_pkg;

   localparam logic [31:0] CRC32_POLY_REFL       = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT            = 32'hFFFFFFFF;
   localparam logic [15:0] CRC16_CCITT_POLY_REFL = 16'h8408;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } crc_state_t;

endpackage

// File: rtl/adbg_crc_step.sv
// Combinational reflected CRC update: absorbs DATA_W bits, data_i[0] first.
module adbg_crc_step #(
   parameter int          CRC_W  = 32,
   parameter logic [31:0] POLY   = 32'hEDB88320,
   parameter int          DATA_W = 1
) (
   input  logic [CRC_W-1:0]  crc_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [CRC_W-1:0]  crc_o
);

   localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];

   logic [CRC_W-1:0] c;

   always_comb begin
      c = crc_i;
      for (int i = 0; i < DATA_W; i++) begin
         c = (c >> 1) ^ ((c[0] ^ data_i[i]) ? POLY_W : '0);
      end
      crc_o = c;
   end

endmodule

// File: rtl/adbg_crc_engine.sv
// Parametrised CRC engine with saturating bit counter, residue match and a
// counted serial shift-out of the register (LSB first).
module adbg_crc_engine
   import adbg_crc_pkg::*;
#(
   parameter int          CRC_W   = 32,
   parameter logic [31:0] POLY    = CRC32_POLY_REFL,
   parameter logic [31:0] INIT    = CRC32_INIT,
   parameter logic [31:0] RESIDUE = 32'h00000000,
   parameter int          DATA_W  = 1,
   parameter int          CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              enable,
   input  logic [DATA_W-1:0] data_i,
   input  logic              start_shift,
   output logic [CRC_W-1:0]  crc_out,
   output logic              crc_match,
   output logic              serial_out,
   output logic              shift_busy,
   output logic              shift_done,
   output logic [CNT_W-1:0]  bit_count,
   output logic              overrun
);

   localparam int               SC_W    = $clog2(CRC_W);
   localparam logic [CRC_W-1:0] INIT_W  = INIT[CRC_W-1:0];
   localparam logic [CRC_W-1:0] RES_W   = RESIDUE[CRC_W-1:0];
   localparam logic [CNT_W:0]   CNT_INC = (CNT_W+1)'(DATA_W);

   crc_state_t       state_q, state_d;
   logic [CRC_W-1:0] crc_q, crc_d, crc_step;
   logic [SC_W-1:0]  scnt_q, scnt_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d, bcnt_sat;
   logic [CNT_W:0]   bsum;
   logic             ovr_q, ovr_d;
   logic             done_q, done_d;

   adbg_crc_step #(
      .CRC_W  (CRC_W),
      .POLY   (POLY),
      .DATA_W (DATA_W)
   ) u_step (
      .crc_i  (crc_q),
      .data_i (data_i),
      .crc_o  (crc_step)
   );

   // Extra carry bit detects wrap so the counter sticks at all ones.
   assign bsum     = {1'b0, bcnt_q} + CNT_INC;
   assign bcnt_sat = bsum[CNT_W] ? '1 : bsum[CNT_W-1:0];

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      scnt_d  = scnt_q;
      bcnt_d  = bcnt_q;
      ovr_d   = ovr_q;
      done_d  = 1'b0;
      if (clr) begin
         state_d = IDLE;
         crc_d   = INIT_W;
         scnt_d  = '0;
         bcnt_d  = '0;
         ovr_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable) begin
                  crc_d  = crc_step;
                  bcnt_d = bcnt_sat;
               end
               if (start_shift) begin
                  state_d = SHIFT;
                  scnt_d  = SC_W'(CRC_W-1);
               end
            end
            SHIFT: begin
               crc_d  = {1'b0, crc_q[CRC_W-1:1]};
               scnt_d = scnt_q - SC_W'(1);
               if (enable) ovr_d = 1'b1;
               if (scnt_q == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         crc_q   <= INIT_W;
         scnt_q  <= '0;
         bcnt_q  <= '0;
         ovr_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         scnt_q  <= scnt_d;
         bcnt_q  <= bcnt_d;
         ovr_q   <= ovr_d;
         done_q  <= done_d;
      end
   end

   assign crc_out    = crc_q;
   assign crc_match  = (crc_q == RES_W);
   assign serial_out = crc_q[0];
   assign shift_busy = (state_q == SHIFT);
   assign shift_done = done_q;
   assign bit_count  = bcnt_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_adbg_crc_engine.sv
// Directed bench: CRC-32 serial/byte-wide, CRC-16 byte-wide, shift-out and hazards.
module tb_adbg_crc_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DUT1: defaults (CRC-32, 1 bit/cycle)
   logic        clr1 = 0, en1 = 0, ss1 = 0;
   logic [0:0]  d1 = '0;
   logic [31:0] crc1;
   logic        m1, so1, bsy1, dn1, ov1;
   logic [15:0] bc1;

   // DUT8: CRC-32, 8 bits/cycle, 7-bit counter to reach saturation quickly
   logic        clr8 = 0, en8 = 0, ss8 = 0;
   logic [7:0]  d8 = '0;
   logic [31:0] crc8;
   logic        m8, so8, bsy8, dn8, ov8;
   logic [6:0]  bc8;

   // DUT16: CRC-16/X-25 register, 8 bits/cycle
   logic        clr16 = 0, en16 = 0, ss16 = 0;
   logic [7:0]  d16 = '0;
   logic [15:0] crc16;
   logic        m16, so16, bsy16, dn16, ov16;
   logic [15:0] bc16;

   adbg_crc_engine u_dut1 (
      .clk(clk), .rst(rst), .clr(clr1), .enable(en1), .data_i(d1),
      .start_shift(ss1), .crc_out(crc1), .crc_match(m1), .serial_out(so1),
      .shift_busy(bsy1), .shift_done(dn1), .bit_count(bc1), .overrun(ov1));

   adbg_crc_engine #(.DATA_W(8), .CNT_W(7)) u_dut8 (
      .clk(clk), .rst(rst), .clr(clr8), .enable(en8), .data_i(d8),
      .start_shift(ss8), .crc_out(crc8), .crc_match(m8), .serial_out(so8),
      .shift_busy(bsy8), .shift_done(dn8), .bit_count(bc8), .overrun(ov8));

   adbg_crc_engine #(.CRC_W(16), .POLY(32'h00008408), .INIT(32'h0000FFFF), .DATA_W(8)) u_dut16 (
      .clk(clk), .rst(rst), .clr(clr16), .enable(en16), .data_i(d16),
      .start_shift(ss16), .crc_out(crc16), .crc_match(m16), .serial_out(so16),
      .shift_busy(bsy16), .shift_done(dn16), .bit_count(bc16), .overrun(ov16));

   int errs = 0;
   int nchk = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] CHK32 = 32'h340BC6D9;

   logic [31:0] sbits;
   logic [31:0] cval;
   logic [7:0]  bval;
   int          nbusy, ndone;

   initial begin
      #12 rst = 1'b0;
      #1;
      check("rst_crc",   crc1, 32'hFFFFFFFF);
      check("rst_busy",  bsy1, 0);
      check("rst_done",  dn1, 0);
      check("rst_bcnt",  bc1, 0);
      check("rst_ovr",   ov1, 0);
      check("rst_match", m1, 0);
      check("rst_crc16", crc16, 16'hFFFF);

      // single-bit steps from INIT
      en1 = 1; d1 = 1'b1; tick(); en1 = 0;
      check("bit1_crc", crc1, 32'h7FFFFFFF);
      check("bit1_bcnt", bc1, 1);
      clr1 = 1; tick(); clr1 = 0;
      check("clr_crc", crc1, 32'hFFFFFFFF);
      check("clr_bcnt", bc1, 0);
      en1 = 1; d1 = 1'b0; tick(); en1 = 0;
      check("bit0_crc", crc1, 32'h92477CDF);
      clr1 = 1; tick(); clr1 = 0;

      // "123456789" byte-wide on DUT8/DUT16
      for (int k = 0; k < 9; k++) begin
         bval = 8'h31 + 8'(k);
         en8 = 1; d8 = bval; en16 = 1; d16 = bval;
         tick();
      end
      en8 = 0; en16 = 0;
      check("byte_crc32", crc8, CHK32);
      check("byte_bcnt", bc8, 72);
      check("byte_crc16", crc16, 16'h6F91);
      check("byte_bcnt16", bc16, 72);

      // same message bit-serially, then append CRC bits for residue
      for (int k = 0; k < 9; k++) begin
         bval = 8'h31 + 8'(k);
         for (int b = 0; b < 8; b++) begin
            en1 = 1; d1 = bval[b]; tick();
         end
      end
      en1 = 0;
      check("ser_crc32", crc1, CHK32);
      check("ser_bcnt", bc1, 72);
      check("ser_nomatch", m1, 0);
      cval = CHK32;
      for (int b = 0; b < 32; b++) begin
         en1 = 1; d1 = cval[b]; tick();
      end
      en1 = 0;
      check("res_match", m1, 1);
      check("res_crc", crc1, 0);

      // shift-out of DUT8 with enable/start_shift hazards inside the shift
      ss8 = 1; tick(); ss8 = 0;
      nbusy = 0; ndone = 0; sbits = '0;
      for (int i = 0; i < 32; i++) begin
         sbits[i] = so8;
         if (bsy8) nbusy++;
         if (dn8) ndone++;
         en8 = (i == 5); d8 = 8'hFF;
         ss8 = (i == 8);
         tick();
      end
      en8 = 0; ss8 = 0;
      check("sh_bits", sbits, CHK32);
      check("sh_busycnt", nbusy, 32);
      check("sh_early_done", ndone, 0);
      check("sh_busy_end", bsy8, 0);
      check("sh_done", dn8, 1);
      check("sh_crc0", crc8, 0);
      check("sh_ovr", ov8, 1);
      check("sh_bcnt_hold", bc8, 72);
      tick();
      check("sh_done_pulse", dn8, 0);
      check("sh_ovr_sticky", ov8, 1);
      clr8 = 1; tick(); clr8 = 0;
      check("clr_ovr", ov8, 0);
      check("clr_crc8", crc8, 32'hFFFFFFFF);

      // clr with enable and start_shift: clr wins
      clr8 = 1; en8 = 1; d8 = 8'h00; ss8 = 1; tick();
      clr8 = 0; en8 = 0; ss8 = 0;
      check("clrwin_crc", crc8, 32'hFFFFFFFF);
      check("clrwin_bcnt", bc8, 0);
      check("clrwin_busy", bsy8, 0);

      // saturating counter: 16 bytes = 128 bits into a 7-bit counter
      for (int k = 0; k < 16; k++) begin
         en8 = 1; d8 = 8'(k); tick();
      end
      en8 = 0;
      check("bcnt_sat", bc8, 7'h7F);

      // enable + start_shift together: absorb first, then shift
      clr1 = 1; tick(); clr1 = 0;
      en1 = 1; d1 = 1'b0; ss1 = 1; tick(); en1 = 0; ss1 = 0;
      check("ens_crc", crc1, 32'h92477CDF);
      check("ens_busy", bsy1, 1);
      check("ens_serial", so1, 1);
      check("ens_bcnt", bc1, 1);
      // clr at shift cycle 10
      for (int i = 1; i < 10; i++) tick();
      clr1 = 1; tick(); clr1 = 0;
      check("abort_crc", crc1, 32'hFFFFFFFF);
      check("abort_busy", bsy1, 0);
      ndone = 0;
      for (int i = 0; i < 4; i++) begin
         if (dn1) ndone++;
         tick();
      end
      check("abort_nodone", ndone, 0);

      // asynchronous reset mid-shift
      clr8 = 1; tick(); clr8 = 0;
      en8 = 1; d8 = 8'h31; tick(); en8 = 0;
      ss8 = 1; tick(); ss8 = 0;
      en8 = 1; tick(); en8 = 0;
      tick();
      check("pre_rst_busy", bsy8, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_crc", crc8, 32'hFFFFFFFF);
      check("arst_busy", bsy8, 0);
      check("arst_bcnt", bc8, 0);
      check("arst_ovr", ov8, 0);
      check("arst_done", dn8, 0);
      #2 rst = 1'b0;
      tick();
      check("post_rst_crc", crc8, 32'hFFFFFFFF);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
